pipe_bus_arbiter: RTL
=====================

Name: pipe_bus_arbiter

Overview:
- Shares one 32-bit single-port memory bus between instruction fetch (IF master) and the MEM stage load/store path (MEM master).
- Sequences each bus transaction with a registered request/ack handshake.
- Generates the 6-bit pipeline stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Handles pipeline flush so that an in-flight fetch is discarded without corrupting the bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for bus_ack; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address, word aligned
- if_rdata  out  32  fetched instruction
- if_ack  out  1  one-cycle pulse: if_rdata valid
- mem_req  in  1  data request, held until mem_ack
- mem_we  in  1  1 = store
- mem_sel  in  4  byte lane enables
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_ack  out  1  one-cycle pulse: access complete
- flush  in  1  pipeline flush (exception/eret)
- stall  out  6  stall[0]=pc … stall[5]=wb; 1 = Stop
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_sel  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  slave completion, single cycle
- bus_err  out  1  sticky timeout flag (BUS_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including if_rdata, mem_rdata and all bus_* outputs.
- States:
  - IDLE, IF_BUSY, IF_DONE, IF_DROP, MEM_BUSY, MEM_DONE.
- IDLE:
  - mem_req=1: load the bus_* registers from mem_* and go to MEM_BUSY.
  - Else if if_req=1 and flush=0: load bus_addr=if_addr, bus_we=0, bus_sel=4'b1111, and go to IF_BUSY.
  - MEM has strict priority over IF.
- Bus outputs are registered. They stay stable from the first active cycle until the cycle bus_ack=1 is sampled; bus_req then drops the next cycle.
- IF_BUSY:
  - bus_ack=1 with flush=0: latch if_rdata<=bus_rdata, go to IF_DONE.
  - bus_ack=1 with flush=1: go to IDLE, no ack.
  - bus_ack=0 with flush=1: go to IF_DROP.
- IF_DROP: the transaction runs to completion. On bus_ack go to IDLE without updating if_rdata and without pulsing if_ack.
- MEM_BUSY: on bus_ack latch mem_rdata<=bus_rdata (stores latch too; the value is don't-care) and go to MEM_DONE. Flush has no effect; a started memory access always completes.
- IF_DONE / MEM_DONE: if_ack / mem_ack =1 for exactly this cycle, then go to IDLE.
- Back-to-back: ack cycle is N, so the earliest next request is sampled in IDLE at N+1 and bus_req reasserts at N+2. Minimum transaction is 3 cycles.
- stall (combinational from state and request inputs):
  - flush=1: 6'b000000.
  - mem_req=1 and state≠MEM_DONE: 6'b011111.
  - Else if_req=1 and state≠IF_DONE: 6'b000111.
  - Else 6'b000000.
- A mem_req arriving while IF_BUSY waits for the fetch to finish. IF_DONE still pulses if_ack, but stall=011111 holds the front end.
- Simultaneous mem_req and if_req in IDLE: MEM is served, and IF is served after MEM_DONE.
- Reset mid-transaction: immediate return to IDLE with bus_req=0. The slave must tolerate the abort.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entering any *_BUSY or IF_DROP state and increments each cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES, treat the cycle as acked with rdata=32'h0 and set bus_err=1. bus_err stays set until reset.
- Undefined: no counter, bus_err is constant 0, and a transaction waits indefinitely.

Decomposition:
- Shared package / define file:
  - State encodings (3 bits).
  - Stall vector constants STALL_NONE=6'b000000, STALL_IF=6'b000111, STALL_MEM=6'b011111.
  - Existing Stop/NoStop, ZeroWord and RstEnable-style constants, with a new active-low reset enable constant.
- Sub-module: bus_timeout_cnt (counter plus compare), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
1. Fetch only: if_req=1, if_addr=32'h100, bus_ack after 2 wait cycles with rdata=32'h2402_0005 → if_ack pulses once, if_rdata=32'h24020005, stall=000111 until the ack cycle.
2. Collision: if_req and mem_req (store, sel=4'b0011, addr=32'h2000, wdata=32'hDEAD_BEEF) both asserted in IDLE → bus shows the store first (bus_we=1, bus_sel=0011), then the fetch; stall=011111 throughout the store.
3. Flush during fetch: flush=1 two cycles into IF_BUSY, bus_ack three cycles later → no if_ack, if_rdata unchanged, bus_req held until ack, then IDLE.
4. Flush during load: flush pulse while MEM_BUSY → the load completes and mem_ack pulses with the bus_rdata value.
5. Async reset asserted mid-MEM_BUSY → all outputs 0 in the same cycle with no clock edge needed; the next request starts cleanly.
6. BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and bus_ack never asserted → after 4 wait cycles mem_ack pulses, mem_rdata=0, bus_err=1 and stays 1.

Source files
------------

// File: rtl/pipe_bus_arbiter_pkg.sv
// Shared encodings and constants for the IF/MEM bus arbiter.
// Stall vectors are indexed pc(0) .. wb(5); a 1 holds that stage.
package pipe_bus_arbiter_pkg;

    localparam logic        RST_ENABLE_N = 1'b0;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, {5{STOP}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_BUSY  = 3'd1,
        ST_IF_DONE  = 3'd2,
        ST_IF_DROP  = 3'd3,
        ST_MEM_BUSY = 3'd4,
        ST_MEM_DONE = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    function automatic logic is_wait_state(arb_state_e s);
        return (s == ST_IF_BUSY) || (s == ST_IF_DROP) || (s == ST_MEM_BUSY);
    endfunction

endpackage

// File: rtl/pipe_bus_arbiter_timeout_cnt.sv
// Bus wait counter: flags a transaction that has gone TIMEOUT_CYCLES
// cycles without bus_ack. Only built when BUS_TIMEOUT_EN is defined.
module bus_timeout_cnt
    import pipe_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt;

    assign expired = busy && !ack && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (busy && !ack && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pipe_bus_arbiter.sv
// Arbitrates one memory bus between fetch (IF) and load/store (MEM).
// Optional wait timeout and sticky bus_err when BUS_TIMEOUT_EN is defined.
module pipe_bus_arbiter
    import pipe_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    input  logic        flush,
    output logic [5:0]  stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    arb_state_e  state, state_n;
    bus_cmd_t    cmd;
    logic        busy;
    logic        ack_eff;
    logic [31:0] rdata_eff;

    assign busy      = is_wait_state(state);
    assign bus_we    = cmd.we;
    assign bus_sel   = cmd.sel;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;
    assign if_ack    = (state == ST_IF_DONE);
    assign mem_ack   = (state == ST_MEM_DONE);

`ifdef BUS_TIMEOUT_EN
    logic tmo;
    logic cnt_clr;

    // Restart the window whenever a new wait state is entered.
    assign cnt_clr   = (state_n != state) && is_wait_state(state_n);
    assign ack_eff   = bus_ack || tmo;
    assign rdata_eff = bus_ack ? bus_rdata : ZERO_WORD;

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .busy   (busy),
        .ack    (bus_ack),
        .expired(tmo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            bus_err <= 1'b0;
        end else if (tmo) begin
            bus_err <= 1'b1;
        end
    end
`else
    logic [7:0] unused_tmo;

    assign unused_tmo = 8'(TIMEOUT_CYCLES);
    assign ack_eff    = bus_ack;
    assign rdata_eff  = bus_rdata;
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    state_n = ST_MEM_BUSY;
                end else if (if_req && !flush) begin
                    state_n = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY: begin
                if (ack_eff) begin
                    state_n = flush ? ST_IDLE : ST_IF_DONE;
                end else if (flush) begin
                    state_n = ST_IF_DROP;
                end
            end
            ST_IF_DROP: begin
                if (ack_eff) begin
                    state_n = ST_IDLE;
                end
            end
            ST_MEM_BUSY: begin
                if (ack_eff) begin
                    state_n = ST_MEM_DONE;
                end
            end
            ST_IF_DONE,
            ST_MEM_DONE: state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // Flush releases the front end even while a fetch is being drained.
    always_comb begin
        stall = STALL_NONE;
        if (flush) begin
            stall = STALL_NONE;
        end else if (mem_req && (state != ST_MEM_DONE)) begin
            stall = STALL_MEM;
        end else if (if_req && (state != ST_IF_DONE)) begin
            stall = STALL_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            bus_req   <= 1'b0;
            if_rdata  <= ZERO_WORD;
            mem_rdata <= ZERO_WORD;
        end else begin
            state <= state_n;
            if (state == ST_IDLE) begin
                if (mem_req) begin
                    bus_req <= 1'b1;
                    cmd     <= '{mem_we, mem_sel, mem_addr, mem_wdata};
                end else if (if_req && !flush) begin
                    bus_req <= 1'b1;
                    cmd     <= '{1'b0, 4'b1111, if_addr, ZERO_WORD};
                end
            end
            if (busy && ack_eff) begin
                bus_req <= 1'b0;
            end
            if ((state == ST_IF_BUSY) && ack_eff && !flush) begin
                if_rdata <= rdata_eff;
            end
            if ((state == ST_MEM_BUSY) && ack_eff) begin
                mem_rdata <= rdata_eff;
            end
        end
    end

endmodule
